// File: rtl/ascon_hash_serial_driver.sv
// Wrapper stage for the bit-serial Ascon hash core. It takes a parallel masked operand bundle,
// shifts it MSB-first into the core, starts the core and deserialises the LSB-first digest.
module ascon_hash_serial_driver #(
    parameter int unsigned Y       = 32,
    parameter int unsigned L       = 256,
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [Y-1:0]   msg,
    input  logic [Y-1:0]   msg_m1,
    input  logic [Y-1:0]   msg_m2,
    input  logic [447:0]   rnd,
    input  logic [L-1:0]   rnd_fault,
    output logic           core_rst,
    output logic [2:0]     core_msg_si,
    output logic [6:0]     core_r64_si,
    output logic           core_rfault_si,
    output logic           core_start_si,
    input  logic           core_hash_so,
    input  logic           core_ready_so,
    output logic [L-1:0]   digest,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           error
);

    localparam int unsigned NYL = (Y > L) ? Y : L;
    localparam int unsigned N   = (NYL > 64) ? NYL : 64;
    localparam int unsigned LW  = $clog2(L);

    typedef enum logic [2:0] {
        StIdle, StCrst, StLoad, StStart, StWait, StCapt, StDone
    } state_e;

    state_e            state_q, state_d;
    logic [31:0]       cnt_q, cnt_d;
    logic [Y-1:0]      msg_sr_q, msg_sr_d;
    logic [Y-1:0]      m1_sr_q, m1_sr_d;
    logic [Y-1:0]      m2_sr_q, m2_sr_d;
    logic [6:0][63:0]  r_sr_q, r_sr_d;
    logic [L-1:0]      rf_sr_q, rf_sr_d;
    logic [2:0]        msg_si_q, msg_si_d;
    logic [6:0]        r_si_q, r_si_d;
    logic              rf_si_q, rf_si_d;
    logic              start_q, start_d;
    logic              core_rst_q, core_rst_d;
    logic [L-1:0]      digest_q, digest_d;
    logic              error_q, error_d;
    // First CAPT cycle is skipped: the core moves its hash bit one edge after ready.
    logic              arm_q, arm_d;
    logic              shift;

    // Next-state, shift-register and registered-output logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        msg_sr_d   = msg_sr_q;
        m1_sr_d    = m1_sr_q;
        m2_sr_d    = m2_sr_q;
        r_sr_d     = r_sr_q;
        rf_sr_d    = rf_sr_q;
        msg_si_d   = '0;
        r_si_d     = '0;
        rf_si_d    = 1'b0;
        start_d    = 1'b0;
        core_rst_d = 1'b0;
        digest_d   = digest_q;
        error_d    = error_q;
        arm_d      = arm_q;
        shift      = 1'b0;

        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    msg_sr_d   = msg;
                    m1_sr_d    = msg_m1;
                    m2_sr_d    = msg_m2;
                    r_sr_d     = rnd;
                    rf_sr_d    = rnd_fault;
                    error_d    = 1'b0;
                    core_rst_d = 1'b1;
                    state_d    = StCrst;
                end
            end
            StCrst: begin
                cnt_d   = '0;
                shift   = 1'b1;
                state_d = StLoad;
            end
            StLoad: begin
                if (cnt_q == 32'(N - 1)) begin
                    cnt_d   = '0;
                    state_d = StStart;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                    shift = 1'b1;
                end
            end
            StStart: begin
                start_d = 1'b1;
                cnt_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                // A ready seen on the first WAIT cycle is stale and ignored.
                if (cnt_q != 32'd0 && core_ready_so) begin
                    cnt_d   = '0;
                    arm_d   = 1'b0;
                    state_d = StCapt;
                end else if (cnt_q == 32'(TIMEOUT - 1)) begin
                    cnt_d      = '0;
                    error_d    = 1'b1;
                    core_rst_d = 1'b1;
                    state_d    = StIdle;
                end else begin
                    start_d = 1'b1;
                    cnt_d   = cnt_q + 32'd1;
                end
            end
            StCapt: begin
                if (!arm_q) begin
                    arm_d = 1'b1;
                end else begin
                    digest_d[cnt_q[LW-1:0]] = core_hash_so;
                    if (cnt_q == 32'(L - 1)) begin
                        cnt_d   = '0;
                        state_d = StDone;
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                    end
                end
            end
            StDone: begin
                if (out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Zero fill means operands shorter than N drive 0 once exhausted.
        if (shift) begin
            msg_si_d = {m2_sr_q[Y-1], m1_sr_q[Y-1], msg_sr_q[Y-1]};
            msg_sr_d = msg_sr_q << 1;
            m1_sr_d  = m1_sr_q << 1;
            m2_sr_d  = m2_sr_q << 1;
            for (int i = 0; i < 7; i++) begin
                r_si_d[i] = r_sr_q[i][63];
                r_sr_d[i] = r_sr_q[i] << 1;
            end
            rf_si_d = rf_sr_q[L-1];
            rf_sr_d = rf_sr_q << 1;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            msg_sr_q   <= '0;
            m1_sr_q    <= '0;
            m2_sr_q    <= '0;
            r_sr_q     <= '0;
            rf_sr_q    <= '0;
            msg_si_q   <= '0;
            r_si_q     <= '0;
            rf_si_q    <= 1'b0;
            start_q    <= 1'b0;
            core_rst_q <= 1'b0;
            digest_q   <= '0;
            error_q    <= 1'b0;
            arm_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            msg_sr_q   <= msg_sr_d;
            m1_sr_q    <= m1_sr_d;
            m2_sr_q    <= m2_sr_d;
            r_sr_q     <= r_sr_d;
            rf_sr_q    <= rf_sr_d;
            msg_si_q   <= msg_si_d;
            r_si_q     <= r_si_d;
            rf_si_q    <= rf_si_d;
            start_q    <= start_d;
            core_rst_q <= core_rst_d;
            digest_q   <= digest_d;
            error_q    <= error_d;
            arm_q      <= arm_d;
        end
    end

    // The core is held in reset for the whole system reset cycle as well.
    assign core_rst       = core_rst_q | rst;
    assign in_ready       = (state_q == StIdle) && !rst;
    assign core_msg_si    = msg_si_q;
    assign core_r64_si    = r_si_q;
    assign core_rfault_si = rf_si_q;
    assign core_start_si  = start_q;
    assign digest         = digest_q;
    assign out_valid      = (state_q == StDone);
    assign error          = error_q;

endmodule

// File: tb/tb_ascon_hash_serial_driver.sv
// Self-checking bench: a stub core answers start with ready and streams a random digest;
// a reference model derives serial bit order and cycle timing from the operand bundle.
module tb_ascon_hash_serial_driver;

    localparam int Y  = 32;
    localparam int L  = 256;
    localparam int N  = 256;
    localparam int TO = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [31:0]  msg = '0, msg_m1 = '0, msg_m2 = '0;
    logic [447:0] rnd = '0;
    logic [255:0] rnd_fault = '0;
    logic         in_ready, core_rst, core_rfault_si, core_start_si, out_valid, error;
    logic [2:0]   core_msg_si;
    logic [6:0]   core_r64_si;
    logic [255:0] digest;
    logic         core_hash_so = 1'b0;
    logic         core_ready_so = 1'b0;

    int checks = 0;
    int errors = 0;
    logic [255:0] prev_digest = '0;

    ascon_hash_serial_driver #(.Y(Y), .L(L), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .msg(msg), .msg_m1(msg_m1), .msg_m2(msg_m2), .rnd(rnd), .rnd_fault(rnd_fault),
        .core_rst(core_rst), .core_msg_si(core_msg_si), .core_r64_si(core_r64_si),
        .core_rfault_si(core_rfault_si), .core_start_si(core_start_si),
        .core_hash_so(core_hash_so), .core_ready_so(core_ready_so),
        .digest(digest), .out_valid(out_valid), .out_ready(out_ready), .error(error)
    );

    always #5 clk = ~clk;

    // Stub core: mode 0 never ready, 1 ready after stub_delay start cycles, 2 ready held high.
    int           stub_mode = 1;
    int           stub_delay = 1;
    int           seen = 0;
    int           sidx = 0;
    logic         start_prev = 1'b0;
    logic         streaming = 1'b0;
    logic [255:0] stub_bits = '0;

    always @(posedge clk) begin
        start_prev <= core_start_si;
        seen <= core_start_si ? seen + 1 : 0;
        case (stub_mode)
            0: core_ready_so <= 1'b0;
            2: core_ready_so <= 1'b1;
            default: core_ready_so <= core_start_si && (seen + 1 >= stub_delay);
        endcase
        // Driver drops start on the edge it samples ready; the digest follows one edge later.
        if (start_prev && !core_start_si) begin
            core_hash_so <= stub_bits[0];
            sidx <= 1;
            streaming <= 1'b1;
        end else if (streaming) begin
            core_hash_so <= stub_bits[sidx];
            if (sidx == L - 1) streaming <= 1'b0;
            sidx <= sidx + 1;
        end
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One transaction. rst_at: CAPT count at which to hit rst (-1 = none).
    task automatic run_txn(input logic [31:0] m, input logic [31:0] m1, input logic [31:0] m2,
                           input logic [447:0] r, input logic [255:0] rf, input int mode,
                           input int d, input int bp, input int rst_at);
        logic [10:0] ev;
        int          w, exp_c, found;
        logic        ov;
        stub_mode  = mode;
        stub_delay = d;
        for (int i = 0; i < 8; i++) stub_bits[32*i +: 32] = $urandom();
        for (int i = 0; i < 10 && !in_ready; i++) @(negedge clk);
        chk("idle_in_ready", in_ready, 1'b1);
        msg = m; msg_m1 = m1; msg_m2 = m2; rnd = r; rnd_fault = rf;
        in_valid = 1'b1;
        @(negedge clk);
        // Operands need not be held past the accepting edge.
        in_valid = 1'b0;
        msg = ~m; msg_m1 = ~m1; msg_m2 = ~m2; rnd = ~r; rnd_fault = ~rf;
        chk("crst_state", {core_rst, in_ready, error}, 3'b100);
        for (int k = 0; k < N; k++) begin
            @(negedge clk);
            ev[0] = (k < Y) ? m[Y-1-k] : 1'b0;
            ev[1] = (k < Y) ? m1[Y-1-k] : 1'b0;
            ev[2] = (k < Y) ? m2[Y-1-k] : 1'b0;
            for (int i = 0; i < 7; i++) ev[3+i] = (k < 64) ? r[64*i+63-k] : 1'b0;
            ev[10] = (k < L) ? rf[L-1-k] : 1'b0;
            chk($sformatf("load_bits_k%0d", k),
                {core_rfault_si, core_r64_si, core_msg_si}, ev);
        end
        @(negedge clk);
        chk("start_quiet", {core_start_si, core_msg_si, core_r64_si, core_rfault_si}, 0);
        if (mode == 0) begin
            ov = 1'b0;
            for (int c = 1; c <= TO + 2; c++) begin
                @(negedge clk);
                ov |= out_valid;
                if (c == TO) chk("to_before", {error, core_start_si}, 2'b01);
                if (c == TO + 1)
                    chk("to_flag", {error, core_rst, in_ready, core_start_si}, 4'b1110);
                if (c == TO + 2) chk("to_pulse_end", core_rst, 1'b0);
            end
            chk("to_no_valid", ov, 1'b0);
            chk("to_digest_kept", digest, prev_digest);
            return;
        end
        // Ready is visible after stub_delay start edges and sampled one edge later.
        w = (mode == 1) ? d + 1 : 2;
        exp_c = w + L + 2;
        found = -1;
        for (int c = 1; c <= exp_c + 20; c++) begin
            @(negedge clk);
            if (c == 1) chk("wait_start", core_start_si, 1'b1);
            if (rst_at >= 0 && c == w + 2 + rst_at) begin
                rst = 1'b1;
                #1;
                chk("midrst_core_rst", {core_rst, in_ready}, 2'b10);
                @(negedge clk);
                rst = 1'b0;
                #1;
                chk("midrst_idle", {in_ready, out_valid, core_rst, core_start_si}, 4'b1000);
                chk("midrst_digest", digest, 0);
                prev_digest = '0;
                return;
            end
            if (out_valid) begin
                found = c;
                break;
            end
        end
        chk("latency", found, exp_c);
        chk("digest", digest, stub_bits);
        prev_digest = stub_bits;
        for (int i = 0; i < bp; i++) begin
            in_valid = 1'b1;
            msg = $urandom();
            @(negedge clk);
            chk("backpressure", {out_valid, in_ready, digest}, {2'b10, stub_bits});
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("release_idle", {out_valid, in_ready}, 2'b01);
    endtask

    function automatic logic [447:0] rand448();
        logic [447:0] v;
        for (int i = 0; i < 14; i++) v[32*i +: 32] = $urandom();
        return v;
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom();
        return v;
    endfunction

    initial begin
        // Reset held for three cycles.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("rst_core_rst_in_ready", {core_rst, in_ready}, 2'b10);
        end
        chk("rst_outputs", {core_msg_si, core_r64_si, core_rfault_si, core_start_si,
                            out_valid, error}, 0);
        chk("rst_digest", digest, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst", {in_ready, core_rst}, 2'b10);

        // Directed load ordering.
        run_txn(32'h8000_0001, 32'h0, 32'h0, 448'h1, 256'h1, 1, 1, 0, -1);
        // Empty-padded message with back-pressure.
        run_txn(32'h8000_0000, 32'h0, 32'h0, rand448(), '0, 1, 3, 50, -1);
        // Random operands, various ready delays, one stale-ready case.
        run_txn($urandom(), $urandom(), $urandom(), rand448(), rand256(), 1,
                $urandom_range(1, 6), 0, -1);
        run_txn($urandom(), $urandom(), $urandom(), rand448(), rand256(), 2, 1, 0, -1);
        run_txn($urandom(), $urandom(), $urandom(), rand448(), rand256(), 1,
                $urandom_range(1, 10), 3, -1);
        // Timeout, then a transaction must clear the error.
        run_txn($urandom(), $urandom(), $urandom(), rand448(), rand256(), 0, 1, 0, -1);
        run_txn($urandom(), $urandom(), $urandom(), rand448(), rand256(), 1, 2, 0, -1);
        // Reset during capture, then a clean transaction.
        run_txn($urandom(), $urandom(), $urandom(), rand448(), rand256(), 1, 2, 0, 100);
        run_txn($urandom(), $urandom(), $urandom(), rand448(), rand256(), 1,
                $urandom_range(1, 6), 0, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ascon_hash_serial_driver.md
# ascon_hash_serial_driver

Upstream/downstream wrapper stage for the bit-serial Ascon hash core. It accepts a parallel masked message, 7×64 bits of masking randomness and L bits of fault randomness through a valid/ready handshake, and owns the core's synchronous reset. It streams every operand MSB-first into the core's serial inputs, raises start, and deserializes the LSB-first serial digest into a parallel word presented with its own valid/ready handshake.

## Interface
- Y, 32, message width per share (core `y`)
- L, 256, digest / fault-randomness width (core `l`)
- TIMEOUT, 4096, maximum cycles in WAIT before error
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset; synchronous, active-high
- in_valid  in  1  operand bundle valid
- in_ready  out  1  high only in IDLE
- msg, msg_m1, msg_m2  in  Y each  message and its two mask shares
- rnd  in  448  r0..r6 concatenated, r0 in [63:0]
- rnd_fault  in  L  fault-countermeasure randomness
- core_rst  out  1  reset driven to the core
- core_msg_si  out  3  {m2,m1,msg} serial bits
- core_r64_si  out  7  r6..r0 serial bits
- core_rfault_si  out  1  fault-randomness serial bit
- core_start_si  out  1  core start
- core_hash_so  in  1  core serial digest bit
- core_ready_so  in  1  core ready
- digest  out  L  captured hash, bit k = k-th serial bit received
- out_valid  out  1  digest valid
- out_ready  in  1  consumer accepts digest
- error  out  1  sticky timeout flag; cleared by rst or by the next accepted input

## Operation
- N = max(Y, L, 64). Counter width: 32 bits.
- States: IDLE → CRST → LOAD → START → WAIT → CAPT → DONE → IDLE.
- IDLE: in_ready=1. On in_valid, latch all operands into shift registers, go to CRST, clear error.
- CRST: core_rst=1 for exactly 1 cycle; cnt←0.
- LOAD: N cycles. In cycle k, drive msg[Y-1-k] (shares likewise) when k<Y, else 0. Drive r_i[63-k] when k<64, else 0. Drive rnd_fault[L-1-k] when k<L, else 0. Shift registers shift left each cycle.
- START: hold all serial inputs at 0. Wait 1 extra cycle, since the core arms start only after its counter exceeds N. Then core_start_si=1 and go to WAIT.
- WAIT: keep core_start_si=1 until core_ready_so=1 is sampled, then deassert it and go to CAPT with cnt←0.
  - If TIMEOUT cycles elapse first: set error, pulse core_rst for 1 cycle, return to IDLE. digest is unchanged and out_valid stays 0.
- CAPT: the core updates core_hash_so one edge after ready. On L consecutive cycles, starting the cycle after the ready sample, write digest[cnt] ← core_hash_so and increment cnt. Go to DONE when cnt=L-1 is written.
- DONE: out_valid=1, digest stable. On out_ready go to IDLE. This is the back-pressure point: the core is left idle, and no input is accepted until the digest is consumed.
- rst in any state: state=IDLE, cnt=0, all shift registers cleared, core_rst=1 during the rst cycle.

## Timing
- Reset values: in_ready=0 during rst, 1 the cycle after. core_rst=1 during rst. core_msg_si=0, core_r64_si=0, core_rfault_si=0, core_start_si=0, digest=0, out_valid=0, error=0.
- Input handshake: the transfer occurs on the edge where in_valid&in_ready. Operands need not be held after that edge.
- Latency from input accept to out_valid: 1 (CRST) + N (LOAD) + 1 (START) + W (WAIT, core-dependent, ≥1) + L (CAPT) + 1 cycles.
- All core-facing outputs are registered; no combinational path from core_ready_so or core_hash_so to any output.
- Simultaneous out_valid&out_ready with in_valid: in_ready is 0 in DONE, so the new input is taken on the following cycle.
- core_ready_so high on entry to WAIT (stale): ignored for the first WAIT cycle.

## Test plan
- Reset: hold rst 3 cycles → every output at its reset value; core_rst=1 throughout; in_ready=1 on the cycle after release.
- Load ordering: msg=32'h8000_0001, masks 0, rnd r0=64'h1, rnd_fault=1 → core_msg_si[0] is 1 on LOAD cycles 0 and 31, 0 otherwise. core_r64_si[0]=1 only on cycle 63. core_rfault_si=1 only on cycle 255. START reached at LOAD+256.
- End-to-end: empty-padded message 32'h8000_0000 with zero masks → digest equals the golden Ascon-Hash vector. out_valid rises exactly L+1 cycles after the ready sample.
- Back-pressure: hold out_ready=0 for 50 cycles in DONE → digest and out_valid stable, in_ready=0. Release → IDLE next cycle.
- Timeout: stub core keeps ready=0, TIMEOUT=16 → error=1 after 16 WAIT cycles, 1-cycle core_rst pulse, in_ready=1, out_valid never asserted.
- Mid-operation reset: assert rst in CAPT at cnt=100 → IDLE next cycle, digest=0. A new transaction then completes correctly.
